// File: rtl/cpu_pkg.sv
// Shared constants and types for the register file and its reset-sweep sequencer.
package cpu_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH    = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_A0   = 10;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_clear_seq.sv
// Reset sweep sequencer: walks clr_idx over every register index once after reset,
// requesting a zero write per cycle, then parks in RUN.
module reg_clear_seq
    import cpu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     busy,
    output logic                     clr_we,
    output logic [ADDRESS_WIDTH-1:0] clr_idx
);

    localparam logic [ADDRESS_WIDTH-1:0] LastIdx = '1;

    rf_state_t                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            CLEAR: begin
                // Natural wrap of the counter returns it to 0 as we leave CLEAR.
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LastIdx) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign busy    = (state_q == CLEAR);
    assign clr_we  = (state_q == CLEAR);
    assign clr_idx = clr_idx_q;

endmodule

// File: rtl/reg_file_sweep.sv
// 32-entry register file with two combinational read ports, one write port and a
// swept reset. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_sweep
    import cpu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    input  logic [ADDRESS_WIDTH-1:0] AD3,
    input  logic                     WE3,
    input  logic [DATA_WIDTH-1:0]    WD3,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic                     busy
);

    localparam int unsigned              Depth   = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZeroIdx = ADDRESS_WIDTH'(REG_ZERO);
    localparam logic [ADDRESS_WIDTH-1:0] A0Idx   = ADDRESS_WIDTH'(REG_A0);

    logic [DATA_WIDTH-1:0]    regs_q [Depth];
    logic [DATA_WIDTH-1:0]    a0_q;
    logic                     clr_we;
    logic [ADDRESS_WIDTH-1:0] clr_idx;
    logic                     user_we;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_idx;
    logic [DATA_WIDTH-1:0]    wr_data;

    reg_clear_seq #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .busy   (busy),
        .clr_we (clr_we),
        .clr_idx(clr_idx)
    );

    // Reset beats a coincident write; writes during the sweep are dropped, not queued.
    assign user_we = !busy && !rst && WE3 && (AD3 != ZeroIdx);

    always_comb begin
        wr_en   = clr_we || user_we;
        wr_idx  = clr_we ? clr_idx : AD3;
        wr_data = clr_we ? '0 : WD3;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a0_q <= '0;
        end else if (user_we && (AD3 == A0Idx)) begin
            a0_q <= WD3;
        end
    end

    assign a0 = a0_q;

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (!busy) begin
            if (AD1 != ZeroIdx) begin
                RD1 = regs_q[AD1];
            end
            if (AD2 != ZeroIdx) begin
                RD2 = regs_q[AD2];
            end
`ifdef REGFILE_BYPASS_EN
            if (user_we && (AD3 == AD1)) begin
                RD1 = WD3;
            end
            if (user_we && (AD3 == AD2)) begin
                RD2 = WD3;
            end
`else
`endif
        end
    end

endmodule
